cv32e40p_rf_recovery_ctrl: RTL

CV32E40P_RF_RECOVERY_CTRL -- requirements
Module: cv32e40p_rf_recovery_ctrl

---
 rtl/cv32e40p_pkg.sv | 33 +++
 rtl/cv32e40p_rf_recovery_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the cv32e40p register-file recovery controller.
// Holds the recovery FSM state encoding and the NUM_REGS legality check.
package cv32e40p_pkg;

  // Index width: enough to address 64 entries (GPR + FP register file)
  localparam int unsigned RF_RECOVERY_IDX_W = 6;

  // The two supported register-file sizes
  localparam int unsigned RF_RECOVERY_NUM_REGS_GPR    = 32;
  localparam int unsigned RF_RECOVERY_NUM_REGS_GPR_FP = 64;

  // Recovery FSM state encoding (kept as plain constants for legacy users)
  localparam logic [2:0] RF_RECOVERY_IDLE    = 3'd0;
  localparam logic [2:0] RF_RECOVERY_SETBACK = 3'd1;
  localparam logic [2:0] RF_RECOVERY_COPY    = 3'd2;
  localparam logic [2:0] RF_RECOVERY_VERIFY  = 3'd3;
  localparam logic [2:0] RF_RECOVERY_DONE    = 3'd4;

  typedef enum logic [2:0] {
    RFR_IDLE    = RF_RECOVERY_IDLE,
    RFR_SETBACK = RF_RECOVERY_SETBACK,
    RFR_COPY    = RF_RECOVERY_COPY,
    RFR_VERIFY  = RF_RECOVERY_VERIFY,
    RFR_DONE    = RF_RECOVERY_DONE
  } rf_recovery_state_e;

  // Only the GPR-only and GPR+FP register-file sizes can be restored
  function automatic bit rf_recovery_num_regs_legal(input int unsigned num_regs);
    return (num_regs == RF_RECOVERY_NUM_REGS_GPR) ||
           (num_regs == RF_RECOVERY_NUM_REGS_GPR_FP);
  endfunction

endpackage

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file recovery controller for a lockstep cv32e40p pair.
// Sets back the recovering core, copies the healthy core's register file
// two entries per cycle into it, optionally reads everything back to
// check the copy, then pulses done_o.
// Optional feature macro: CV32E40P_RF_RECOVERY_VERIFY_EN enables the
// readback VERIFY pass and error_o; without it error_o and the
// destination read addresses are tied to 0.
module cv32e40p_rf_recovery_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,

  output logic        setback_o,
  output logic        recover_o,
  output logic        backup_o,

  output logic [5:0]  src_raddr_a_o,
  output logic [5:0]  src_raddr_b_o,
  input  logic [31:0] src_rdata_a_i,
  input  logic [31:0] src_rdata_b_i,

  output logic        we_a_o,
  output logic        we_b_o,
  output logic [5:0]  waddr_a_o,
  output logic [5:0]  waddr_b_o,
  output logic [31:0] wdata_a_o,
  output logic [31:0] wdata_b_o,

  output logic [5:0]  dst_raddr_a_o,
  output logic [5:0]  dst_raddr_b_o,
  input  logic [31:0] dst_rdata_a_i,
  input  logic [31:0] dst_rdata_b_i
);

  if (!rf_recovery_num_regs_legal(NUM_REGS)) begin : g_illegal_num_regs
    $error("cv32e40p_rf_recovery_ctrl: NUM_REGS must be 32 or 64");
  end

  // Index of the last even/odd pair handled in COPY and VERIFY
  localparam logic [RF_RECOVERY_IDX_W-1:0] LAST_IDX = RF_RECOVERY_IDX_W'(NUM_REGS - 2);

  rf_recovery_state_e state_q, state_d;
  logic [RF_RECOVERY_IDX_W-1:0] idx_q, idx_d;
  logic [RF_RECOVERY_IDX_W-1:0] idx_b;
  logic last_pair;

  // Port B always handles the odd partner of the even entry on port A
  assign idx_b     = idx_q + RF_RECOVERY_IDX_W'(1);
  assign last_pair = (idx_q == LAST_IDX);

  // Next-state and index sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      RFR_IDLE: begin
        if (start_i) begin
          state_d = RFR_SETBACK;
        end
      end
      RFR_SETBACK: begin
        idx_d   = '0;
        state_d = RFR_COPY;
      end
      RFR_COPY: begin
        if (last_pair) begin
          idx_d = '0;
`ifdef CV32E40P_RF_RECOVERY_VERIFY_EN
          state_d = RFR_VERIFY;
`else
          state_d = RFR_DONE;
`endif
        end else begin
          idx_d = idx_q + RF_RECOVERY_IDX_W'(2);
        end
      end
`ifdef CV32E40P_RF_RECOVERY_VERIFY_EN
      RFR_VERIFY: begin
        if (last_pair) begin
          idx_d   = '0;
          state_d = RFR_DONE;
        end else begin
          idx_d = idx_q + RF_RECOVERY_IDX_W'(2);
        end
      end
`endif
      RFR_DONE: begin
        idx_d   = '0;
        state_d = RFR_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = RFR_IDLE;
      end
    endcase
  end

  // State and index registers; reset aborts any sequence in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RFR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Moore output decode; every unused address/data field stays at zero
  always_comb begin
    busy_o        = (state_q != RFR_IDLE);
    done_o        = 1'b0;
    setback_o     = 1'b0;
    recover_o     = 1'b0;
    backup_o      = 1'b0;
    src_raddr_a_o = '0;
    src_raddr_b_o = '0;
    we_a_o        = 1'b0;
    we_b_o        = 1'b0;
    waddr_a_o     = '0;
    waddr_b_o     = '0;
    wdata_a_o     = '0;
    wdata_b_o     = '0;
    unique case (state_q)
      RFR_SETBACK: begin
        setback_o = 1'b1;
      end
      RFR_COPY: begin
        recover_o     = 1'b1;
        backup_o      = 1'b1;
        src_raddr_a_o = idx_q;
        src_raddr_b_o = idx_b;
        we_a_o        = 1'b1;
        we_b_o        = 1'b1;
        waddr_a_o     = idx_q;
        waddr_b_o     = idx_b;
        wdata_a_o     = src_rdata_a_i;
        wdata_b_o     = src_rdata_b_i;
      end
      RFR_VERIFY: begin
        backup_o      = 1'b1;
        src_raddr_a_o = idx_q;
        src_raddr_b_o = idx_b;
      end
      RFR_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = (state_q != RFR_IDLE);
      end
    endcase
  end

`ifdef CV32E40P_RF_RECOVERY_VERIFY_EN
  logic err_q;
  logic pair_mismatch;

  // Either lane of the current pair disagreeing between source and copy
  assign pair_mismatch = (src_rdata_a_i != dst_rdata_a_i) ||
                         (src_rdata_b_i != dst_rdata_b_i);

  // Sticky mismatch flag: set during VERIFY, cleared as DONE is left
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == RFR_VERIFY) && pair_mismatch) begin
      err_q <= 1'b1;
    end else if (state_q == RFR_DONE) begin
      err_q <= 1'b0;
    end
  end

  assign error_o       = done_o & err_q;
  assign dst_raddr_a_o = (state_q == RFR_VERIFY) ? idx_q : '0;
  assign dst_raddr_b_o = (state_q == RFR_VERIFY) ? idx_b : '0;
`else
  logic unused_dst_rdata;

  assign unused_dst_rdata = ^{dst_rdata_a_i, dst_rdata_b_i};
  assign error_o          = 1'b0;
  assign dst_raddr_a_o    = '0;
  assign dst_raddr_b_o    = '0;
`endif

endmodule
